// File: rtl/priority_pending_dispatcher.sv
// Sticky pending-request dispatcher: offers the highest enabled pending index as a registered code.
// Two cycles from req_in to out_valid when idle, back-to-back while ready; offer held without preemption under backpressure.
module priority_pending_dispatcher #(
  parameter int         NREQ      = 16,
  parameter logic [7:0] IDLE_CODE = 8'hF0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_in,
  input  logic [NREQ-1:0] mask,
  input  logic            out_ready,
  input  logic            clr_ovf,
  output logic [7:0]      out_code,
  output logic            out_valid,
  output logic [NREQ-1:0] pending_o,
  output logic            overflow
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state;
  logic [NREQ-1:0] pending;
  logic            hs;
  logic [NREQ-1:0] gbit;
  logic [NREQ-1:0] cand;
  logic [3:0]      sel_idx;
  logic            cand_any;

  assign hs        = out_valid & out_ready;
  assign gbit      = hs ? (NREQ'(1) << out_code[3:0]) : '0;
  // The line being accepted this edge is no longer a candidate.
  assign cand      = pending & mask & ~gbit;
  assign cand_any  = |cand;
  assign pending_o = pending;

  always_comb begin
    sel_idx = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (cand[i]) sel_idx = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_code  <= IDLE_CODE;
      overflow  <= 1'b0;
    end else begin
      pending <= (pending & ~gbit) | req_in;

      if (|(req_in & pending & ~gbit)) overflow <= 1'b1;
      else if (clr_ovf)                overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (cand_any) begin
            out_code  <= {4'b0, sel_idx};
            out_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (hs) begin
            if (cand_any) begin
              out_code <= {4'b0, sel_idx};
            end else begin
              out_code  <= IDLE_CODE;
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_code  <= IDLE_CODE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_pending_dispatcher.sv
// Directed bench: stimulus pushes expected accepted codes; a negedge monitor pops them on each handshake.
module tb_priority_pending_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req_in;
  logic [15:0] mask;
  logic        out_ready;
  logic        clr_ovf;
  logic [7:0]  out_code;
  logic        out_valid;
  logic [15:0] pending_o;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  priority_pending_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .out_code(out_code),
    .out_valid(out_valid), .pending_o(pending_o), .overflow(overflow)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor: every accepted offer must match the next expected code.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_accept: got code %h expected none", out_code);
      end else begin
        check("accept_code", {8'h00, out_code}, {8'h00, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_in = '0; mask = 16'hFFFF; out_ready = 1'b0; clr_ovf = 1'b0;

    // Reset then idle
    tick(); tick();
    rst_n = 1'b1;
    at_neg();
    check("rst_code", {8'h00, out_code}, 16'h00F0);
    check("rst_valid", {15'b0, out_valid}, 16'h0000);
    check("rst_pending", pending_o, 16'h0000);
    check("rst_ovf", {15'b0, overflow}, 16'h0000);

    // Single request: two-cycle latency, cleared on accept
    tick();
    req_in = 16'h0020; out_ready = 1'b1; exp_q.push_back(8'd5);
    tick();
    req_in = '0;
    at_neg();
    check("single_pending", pending_o, 16'h0020);
    check("single_valid_early", {15'b0, out_valid}, 16'h0000);
    tick();
    at_neg();
    check("single_valid", {15'b0, out_valid}, 16'h0001);
    check("single_code", {8'h00, out_code}, 16'h0005);
    tick();
    at_neg();
    check("single_pending_clr", pending_o, 16'h0000);
    check("single_idle_code", {8'h00, out_code}, 16'h00F0);

    // Priority drain, back-to-back
    req_in = 16'h8101;
    exp_q.push_back(8'd15); exp_q.push_back(8'd8); exp_q.push_back(8'd0);
    tick();
    req_in = '0;
    tick(); at_neg(); check("drain_0", {8'h00, out_code}, 16'h000F);
    tick(); at_neg(); check("drain_1", {8'h00, out_code}, 16'h0008);
    tick(); at_neg(); check("drain_2", {8'h00, out_code}, 16'h0000);
    tick(); at_neg(); check("drain_idle", {8'h00, out_code}, 16'h00F0);
    check("drain_valid", {15'b0, out_valid}, 16'h0000);

    // Backpressure, no preemption
    out_ready = 1'b0; req_in = 16'h0008;
    tick();
    req_in = '0;
    tick(); at_neg(); check("bp_offer", {8'h00, out_code}, 16'h0003);
    req_in = 16'h1000;
    tick();
    req_in = '0;
    tick(); at_neg();
    check("bp_hold", {8'h00, out_code}, 16'h0003);
    check("bp_hold_valid", {15'b0, out_valid}, 16'h0001);
    check("bp_pending", pending_o, 16'h1008);
    exp_q.push_back(8'd3); exp_q.push_back(8'd12);
    out_ready = 1'b1;
    tick(); at_neg(); check("bp_next", {8'h00, out_code}, 16'h000C);
    tick(); at_neg(); check("bp_idle", {15'b0, out_valid}, 16'h0000);

    // Mask and overflow
    out_ready = 1'b0; mask = 16'h00FF; req_in = 16'h0F00;
    tick();
    req_in = '0;
    tick(); tick(); at_neg();
    check("mask_novalid", {15'b0, out_valid}, 16'h0000);
    check("mask_pending", pending_o, 16'h0F00);
    mask = 16'hFFFF;
    tick(); at_neg();
    check("mask_offer", {8'h00, out_code}, 16'h000B);
    req_in = 16'h0800;
    tick();
    req_in = '0;
    at_neg(); check("ovf_set", {15'b0, overflow}, 16'h0001);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    at_neg(); check("ovf_clr", {15'b0, overflow}, 16'h0000);
    // Accept 11 while re-requesting 11: bit stays as a new event, then full drain.
    out_ready = 1'b1; req_in = 16'h0800;
    exp_q.push_back(8'd11); exp_q.push_back(8'd10); exp_q.push_back(8'd11);
    exp_q.push_back(8'd9);  exp_q.push_back(8'd8);
    tick();
    req_in = '0;
    at_neg();
    check("rereq_ovf", {15'b0, overflow}, 16'h0000);
    check("rereq_pending", pending_o, 16'h0F00);
    tick(); tick(); tick(); tick(); at_neg();
    check("rereq_drained", pending_o, 16'h0000);
    check("rereq_idle", {15'b0, out_valid}, 16'h0000);

    // Reset mid-offer
    out_ready = 1'b0; req_in = 16'h0006;
    tick();
    req_in = '0;
    tick(); at_neg();
    check("mid_offer", {8'h00, out_code}, 16'h0002);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    at_neg();
    check("mid_rst_valid", {15'b0, out_valid}, 16'h0000);
    check("mid_rst_pending", pending_o, 16'h0000);
    check("mid_rst_code", {8'h00, out_code}, 16'h00F0);

    tick(); tick(); at_neg();
    check("queue_empty", 16'(exp_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/priority_pending_dispatcher.md
Name: priority_pending_dispatcher

Overview:
Sits directly downstream of the 16-to-4 priority encode stage and makes its combinational result sequential. It captures request lines into a sticky pending register and repeatedly selects the highest-index enabled pending request. Each selection is offered as an 8-bit code with a valid/ready handshake, and the serviced bit is cleared on acceptance. Output code format matches the encoder: 0..15 for an index, 8'hF0 when nothing is offered.

Parameters:
NREQ, 16, number of request lines (index width fixed at 4 bits; only 16 supported)
IDLE_CODE, 8'hF0, value driven on out_code whenever out_valid=0

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
req_in  input  16  request pulses/levels; each cycle, any high bit is ORed into pending
mask  input  16  per-line enable; 1=line eligible for selection (pending still captured when 0)
out_ready  input  1  consumer accepts the offered code when high together with out_valid
clr_ovf  input  1  clears the sticky overflow flag
out_code  output  8  offered index {4'b0,idx} when out_valid=1, else IDLE_CODE
out_valid  output  1  offer valid
pending_o  output  16  current pending register
overflow  output  1  sticky: a request hit an already-pending, not-being-cleared line

Behaviour:
- Reset (rst_n=0 at a clock edge): pending=0, state=IDLE, out_valid=0, out_code=8'hF0, overflow=0. Reset overrides all other inputs that cycle. Reset mid-offer drops the offer without a handshake.
- hs = out_valid & out_ready. gbit = one-hot of the granted index when hs=1, else 0.
- Pending update: pending <= (pending & ~gbit) | req_in.
  - req_in[i]=1 in the same cycle line i is accepted leaves bit i set as a new event; no overflow.
- Candidate set: cand = pending & mask & ~gbit. Selection uses the registered pending only; req_in in the same cycle is not a candidate.
- Selection: highest set index in cand (bit 15 highest priority), same priority order as the encoder.
- States:
  - IDLE (out_valid=0, out_code=IDLE_CODE): if cand != 0, register idx, set out_valid=1, go to OFFER. Otherwise stay.
  - OFFER (out_valid=1):
    - If !out_ready: hold out_code/out_valid stable. No preemption by higher-priority arrivals. Mask changes do not withdraw the offer.
    - If hs and cand != 0: load the next idx the same edge (back-to-back, no bubble) and stay in OFFER.
    - If hs and cand == 0: go to IDLE with out_valid=0 and out_code=IDLE_CODE.
- Latency: req_in high at edge N gives pending at N+1 and out_valid at N+2 (two cycles from IDLE). Sustained out_ready=1 with k eligible pending bits gives k consecutive accepts.
- Overflow: set when any i has req_in[i] & pending[i] & ~gbit[i]. If clr_ovf and a new overflow occur in the same cycle, set wins. Otherwise clr_ovf clears it.
- The granted bit stays visible in pending_o until the accepting edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, req_in=0 -> out_code=8'hF0, out_valid=0, pending_o=0, overflow=0.
- Single request: mask=16'hFFFF, req_in=16'h0020 for one cycle at edge N, out_ready=1 -> out_valid=1 with out_code=8'd5 at N+2. Accept at N+2 clears it: pending_o=0 and out_code=8'hF0 at N+3.
- Priority drain, back-to-back: pulse req_in=16'h8101, out_ready=1 -> out_code sequence 15, 8, 0 on three consecutive cycles, then 8'hF0.
- Backpressure/no preemption: offer idx 3 with out_ready=0, then pulse req_in[12] -> out_code stays 3 until out_ready=1. The next offer is 12.
- Mask and overflow:
  - mask=16'h00FF with pending=16'h0F00 -> no offer.
  - Setting mask=16'hFFFF -> offer 11.
  - req_in[11] again while offered and out_ready=0 -> overflow=1.
  - clr_ovf -> overflow=0.
  - Accepting line 11 while req_in[11]=1 -> bit 11 stays pending, no overflow.
- Reset mid-offer: offer active with pending=16'h0006, assert rst_n=0 -> next edge out_valid=0, pending_o=0, out_code=8'hF0.
